multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RISC-V lab core. It latches each fetched instruction, decodes the opcode, and drives ImmSrc into the sign-extension unit. It also sequences ALU source/op, register-file write, data-memory access and PC update over 3–5+ cycles per instruction. It sits between instruction memory and the shared datapath (sign extend, ALU, register file, data memory, PC register), so one ALU and one memory port are reused across instruction phases.

---
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM driving the shared datapath.
// Optional lui support: define CTRL_LUI_EN.
module multicycle_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic [2:0]            ImmSrc,
  output logic                  ALUsrc,
  output logic [2:0]            ALUctrl,
  output logic                  RegWrite,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic                  ResultSrc,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  illegal,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  ill_q, ill_d;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       is_addi, is_lw, is_sw;
  logic       is_beq, is_bne, is_br;
  logic       is_lui, is_mem;
  logic [2:0] imm_sel;
  logic       unused_ir;

  assign opc       = ir_q[6:0];
  assign f3        = ir_q[14:12];
  assign unused_ir = ^{ir_q[DATA_WIDTH-1:15], ir_q[11:7]};

  assign is_addi = (opc == 7'b0010011) && (f3 == 3'b000);
  assign is_lw   = (opc == 7'b0000011) && (f3 == 3'b010);
  assign is_sw   = (opc == 7'b0100011) && (f3 == 3'b010);
  assign is_beq  = (opc == 7'b1100011) && (f3 == 3'b000);
  assign is_bne  = (opc == 7'b1100011) && (f3 == 3'b001);
  assign is_br   = is_beq | is_bne;
  assign is_mem  = is_lw | is_sw;
`ifdef CTRL_LUI_EN
  assign is_lui  = (opc == 7'b0110111);
`else
  assign is_lui  = 1'b0;
`endif

  always_comb begin
    imm_sel = 3'd0;
    unique case (1'b1)
      is_sw:   imm_sel = 3'd1;
      is_br:   imm_sel = 3'd2;
      is_lui:  imm_sel = 3'd3;
      default: imm_sel = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_addi, is_mem, is_br: state_d = S_EXEC;
          is_lui:                 state_d = S_WB;
          default: begin
            state_d = S_TRAP;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          is_br:   state_d = S_FETCH;
          is_addi: state_d = S_WB;
          default: state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        if (mem_ready)
          state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // ALU operands stay selected through MEM/WB: the datapath has no ALUOut latch.
  always_comb begin
    ImmSrc    = 3'd0;
    ALUsrc    = 1'b0;
    ALUctrl   = 3'b000;
    RegWrite  = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_DECODE: ImmSrc = imm_sel;
        S_EXEC: begin
          ImmSrc = imm_sel;
          if (is_br) begin
            ALUctrl = 3'b001;
            PCWrite = 1'b1;
            PCsrc   = is_bne ? ~zero : zero;
          end else begin
            ALUsrc = 1'b1;
          end
        end
        S_MEM: begin
          ImmSrc   = imm_sel;
          ALUsrc   = 1'b1;
          MemRead  = is_lw;
          MemWrite = is_sw;
          PCWrite  = is_sw & mem_ready;
        end
        S_WB: begin
          ImmSrc    = imm_sel;
          ALUsrc    = 1'b1;
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
          ResultSrc = is_lw;
        end
        default: ;
      endcase
    end
  end

  assign illegal = ill_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl.
// Directed vectors; expected outputs queued per cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] imm;
    logic       asrc;
    logic [2:0] actl;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       rs;
    logic       pw;
    logic       pc;
    logic       ill;
  } out_t;

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] BNE  = 32'h00209463;
  localparam logic [31:0] BEQ  = 32'h00208463;
  localparam logic [31:0] LW   = 32'h0000A103;
  localparam logic [31:0] SW   = 32'h0020A023;
  localparam logic [31:0] ILL  = 32'hFFFFFFFF;
  localparam logic [31:0] LUI  = 32'h000000B7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  ImmSrc;
  logic        ALUsrc;
  logic [2:0]  ALUctrl;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        ResultSrc;
  logic        PCWrite;
  logic        PCsrc;
  logic        illegal;
  logic [2:0]  state;

  int checks = 0;
  int failures = 0;

  out_t  exp_q[$];
  string name_q[$];

  multicycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .instr_valid(instr_valid), .zero(zero),
    .mem_ready(mem_ready), .ImmSrc(ImmSrc),
    .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
    .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .PCWrite(PCWrite), .PCsrc(PCsrc),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(
    input logic [2:0] st, input logic [2:0] imm,
    input logic asrc, input logic [2:0] actl,
    input logic rw, input logic mr, input logic mw,
    input logic rs, input logic pw, input logic pc,
    input logic ill);
    out_t o;
    o = '{st, imm, asrc, actl, rw, mr, mw, rs, pw, pc, ill};
    return o;
  endfunction

  out_t F0;
  out_t TRAP;
  assign F0   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  assign TRAP = mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

  task automatic step(
    input logic [31:0] in, input logic v,
    input logic z, input logic r, input logic rn,
    input out_t e, input string nm);
    @(posedge clk);
    #1;
    instr       = in;
    instr_valid = v;
    zero        = z;
    mem_ready   = r;
    rst_n       = rn;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    out_t  e;
    out_t  a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{state, ImmSrc, ALUsrc, ALUctrl, RegWrite,
            MemRead, MemWrite, ResultSrc, PCWrite,
            PCsrc, illegal};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %b want %b", n, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    step(0, 0, 0, 0, 0, F0, "reset0");
    step(0, 0, 0, 0, 0, F0, "reset1");

    step(ADDI, 1, 0, 0, 1, F0, "addi_F");
    step(ILL, 1, 0, 0, 1,
      mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addi_D");
    step(0, 0, 0, 1, 1,
      mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "addi_E");
    step(0, 0, 0, 0, 1,
      mk(4, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0), "addi_WB");
    step(0, 0, 0, 0, 1, F0, "addi_done");

    step(BNE, 1, 0, 0, 1, F0, "bne0_F");
    step(0, 0, 0, 0, 1,
      mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bne0_D");
    step(0, 0, 0, 0, 1,
      mk(2, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0), "bne0_E");
    step(0, 0, 0, 0, 1, F0, "bne0_done");

    step(BNE, 1, 1, 0, 1, F0, "bne1_F");
    step(0, 0, 1, 0, 1,
      mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bne1_D");
    step(0, 0, 1, 0, 1,
      mk(2, 2, 0, 1, 0, 0, 0, 0, 1, 0, 0), "bne1_E");
    step(0, 0, 1, 0, 1, F0, "bne1_done");

    step(BEQ, 1, 1, 0, 1, F0, "beq1_F");
    step(0, 0, 1, 0, 1,
      mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beq1_D");
    step(0, 0, 1, 0, 1,
      mk(2, 2, 0, 1, 0, 0, 0, 0, 1, 1, 0), "beq1_E");
    step(0, 0, 0, 0, 1, F0, "beq1_done");

    step(LW, 1, 0, 0, 1, F0, "lw_F");
    step(0, 0, 0, 0, 1,
      mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lw_D");
    step(0, 0, 0, 0, 1,
      mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "lw_E");
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 1,
        mk(3, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0), "lw_M_wait");
    step(0, 0, 0, 1, 1,
      mk(3, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0), "lw_M_rdy");
    step(0, 0, 0, 0, 1,
      mk(4, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0), "lw_WB");
    step(0, 0, 0, 0, 1, F0, "lw_done");

    step(SW, 1, 0, 1, 1, F0, "sw_F");
    step(0, 0, 0, 1, 1,
      mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw_D");
    step(0, 0, 0, 1, 1,
      mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sw_E");
    step(0, 0, 0, 1, 1,
      mk(3, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0), "sw_M");
    step(0, 0, 0, 0, 1, F0, "sw_done");

    step(SW, 1, 0, 0, 1, F0, "sw2_F");
    step(0, 0, 0, 0, 1,
      mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sw2_D");
    step(0, 0, 0, 0, 1,
      mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sw2_E");
    step(0, 0, 0, 0, 1,
      mk(3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0), "sw2_M_wait");
    step(0, 0, 0, 1, 1,
      mk(3, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0), "sw2_M_rdy");
    step(0, 0, 0, 0, 1, F0, "sw2_done");

    step(ILL, 1, 0, 0, 1, F0, "ill_F");
    step(0, 0, 0, 0, 1,
      mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_D");
    for (int i = 0; i < 20; i++) begin
      logic t;
      t = 1'(i % 2);
      step(ADDI, t, t, t, 1, TRAP, "ill_trap");
    end
    step(0, 0, 0, 0, 0, TRAP, "ill_rst");
    step(0, 0, 0, 0, 1, F0, "ill_cleared");

    step(LW, 1, 0, 0, 1, F0, "lwr_F");
    step(0, 0, 0, 0, 1,
      mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lwr_D");
    step(0, 0, 0, 0, 1,
      mk(2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "lwr_E");
    step(0, 0, 0, 0, 1,
      mk(3, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0), "lwr_M");
    step(0, 0, 0, 1, 0,
      mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lwr_rst");
    step(LUI, 1, 0, 0, 1, F0, "lui_F");
`ifdef CTRL_LUI_EN
    step(0, 0, 0, 0, 1,
      mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lui_D");
    step(0, 0, 0, 0, 1,
      mk(4, 3, 1, 0, 1, 0, 0, 0, 1, 0, 0), "lui_WB");
    step(0, 0, 0, 0, 1, F0, "lui_done");
`else
    step(0, 0, 0, 0, 1,
      mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "lui_D");
    step(0, 0, 0, 0, 1, TRAP, "lui_trap");
    step(0, 0, 0, 0, 1, TRAP, "lui_trap2");
`endif

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0",
        exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
